// File: rtl/wb_host_pkg.sv
// Shared widths and FSM state encoding for the Wishbone host master.
package wb_host_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_host_state_e;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT_CYCLES-th enabled edge is about to occur.
module wb_host_timeout #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LastCnt = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt_q;

  // Cycle counter: cleared on reset and on entry to a bus cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  // High while the edge that completes the TIMEOUT_CYCLES-th bus cycle is pending.
  assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic (B4, non-pipelined) initiator driven by a valid/ready command
// port, returning read data and status on a valid/ready response port.
// Optional: define WB_HOST_MASTER_ERR_EN to add wbm_err_i as a bus-error termination.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  // Command port
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  // Response port
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  // Wishbone master
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
`ifdef WB_HOST_MASTER_ERR_EN
  input  logic                wbm_err_i,
`endif
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy_o
);

  wb_host_state_e      state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [WB_DAT_W-1:0] rsp_dat_q;
  logic                rsp_err_q;
  logic                cyc_q;
  logic                stb_q;
  logic                we_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic [WB_ADR_W-1:0] adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic                busy_q;

  logic                bus_err;
  logic                accept;
  logic                expired;

`ifdef WB_HOST_MASTER_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_q;

  wb_host_timeout #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .clear_i   (accept),
    .enable_i  (state_q == ST_BUS),
    .expired_o (expired)
  );

  // Command/bus/response sequencer; every output is a register set here.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Termination priority: ack > err > timeout.
          if (wbm_ack_i) begin
            rsp_dat_q <= we_q ? '0 : wbm_dat_i;
            rsp_err_q <= 1'b0;
          end else if (bus_err || expired) begin
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b1;
          end
          if (wbm_ack_i || bus_err || expired) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: directed table, randomized vectors against a
// termination-time model, plus a hand-written reset-during-bus sequence.
module tb_wb_host_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack = 1'b0;
  logic        berr = 1'b0;
  logic [31:0] sdat = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_host_master #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_ack_i   (ack),
`ifdef WB_HOST_MASTER_ERR_EN
    .wbm_err_i   (berr),
`endif
    .wbm_dat_i   (sdat),
    .busy_o      (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] sdata;   // data the slave returns on ack
    int          ack_dly; // BUS cycle (1-based) in which slave acks; 0 = never
    int          err_dly; // BUS cycle in which slave raises err; 0 = never
    int          hold;    // cycles rsp_ready is held low in RESP
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_lat; // cycles from accept edge to first rsp_valid cycle
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: bus cycle ends at the earliest terminating event, ack winning ties.
  function automatic void model(input logic we_i, input logic [31:0] sd, input int ad,
                                input int ed, output logic e_err, output logic [31:0] e_dat,
                                output int e_lat);
    int a_t, r_t;
    a_t = (ad >= 1 && ad <= TO) ? ad : 1000;
`ifdef WB_HOST_MASTER_ERR_EN
    r_t = (ed >= 1 && ed <= TO) ? ed : 1000;
`else
    r_t = 1000 + ed * 0;
`endif
    if (a_t <= r_t && a_t <= TO) begin
      e_err = 1'b0; e_dat = we_i ? 32'h0 : sd; e_lat = a_t + 1;
    end else if (r_t <= TO) begin
      e_err = 1'b1; e_dat = 32'h0; e_lat = r_t + 1;
    end else begin
      e_err = 1'b1; e_dat = 32'h0; e_lat = TO + 1;
    end
  endfunction

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] sd, input int ad,
                              input int ed, input int h, input logic ee,
                              input logic [31:0] edat, input int el);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s; v.sdata = sd;
    v.ack_dly = ad; v.err_dly = ed; v.hold = h;
    v.exp_err = ee; v.exp_dat = edat; v.exp_lat = el;
    return v;
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge after the response handshake.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, cyc_n;
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({p, "_idle_busy"}, 32'(busy), 32'd0);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~v.we; cmd_adr = $urandom; cmd_dat = $urandom;
    lat = 0; cyc_n = 0;
    for (int k = 1; k <= TO + 6; k++) begin
      if (rsp_valid) begin lat = k; break; end
      if (cyc) cyc_n++;
      if (k == 1) begin
        chk({p, "_cyc"}, 32'(cyc), 32'd1);
        chk({p, "_stb"}, 32'(stb), 32'd1);
        chk({p, "_we"}, 32'(we), 32'(v.we));
        chk({p, "_adr"}, adr, v.adr);
        chk({p, "_sel"}, 32'(sel), 32'(v.sel));
        if (v.we) chk({p, "_wdat"}, wdat, v.dat);
        chk({p, "_bus_ready"}, 32'(cmd_ready), 32'd0);
        chk({p, "_bus_busy"}, 32'(busy), 32'd1);
      end
      ack = (k == v.ack_dly);
      berr = (k == v.err_dly);
      sdat = ack ? v.sdata : $urandom;
      rsp_ready = 1'($urandom);  // no effect outside RESP
      @(negedge clk);
    end
    ack = 1'b0; berr = 1'b0; rsp_ready = 1'b0;
    chk({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({p, "_rsp_dat"}, rsp_dat, v.exp_dat);
    chk({p, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({p, "_cyc_len"}, 32'(cyc_n), 32'(v.exp_lat - 1));
    chk({p, "_resp_cyc"}, 32'(cyc), 32'd0);
    // Hold off the response while offering a competing command.
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1; cmd_we = 1'($urandom); cmd_adr = $urandom;
      ack = 1'($urandom);  // stray ack in RESP must be ignored
      @(negedge clk);
      chk({p, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({p, "_hold_dat"}, rsp_dat, v.exp_dat);
      chk({p, "_hold_err"}, 32'(rsp_err), 32'(v.exp_err));
      chk({p, "_hold_ready"}, 32'(cmd_ready), 32'd0);
      chk({p, "_hold_cyc"}, 32'(cyc), 32'd0);
    end
    cmd_valid = 1'b0; ack = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({p, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({p, "_post_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-derived expectations (TO = 8)
    tbl.push_back(mk(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 32'hDEAD_BEEF, 3, 0, 0,
                     1'b0, 32'h0, 4));
    tbl.push_back(mk(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 1, 0, 0,
                     1'b0, 32'hCAFE_F00D, 2));
    tbl.push_back(mk(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1111_2222, 0, 0, 0,
                     1'b1, 32'h0, 9));
    tbl.push_back(mk(1'b0, 32'h3000_000C, 32'h0, 4'h1, 32'h1234_5678, 8, 0, 1,
                     1'b0, 32'h1234_5678, 9));
    tbl.push_back(mk(1'b0, 32'h3000_0010, 32'h0, 4'h2, 32'h8765_4321, 9, 0, 0,
                     1'b1, 32'h0, 9));
    tbl.push_back(mk(1'b0, 32'h3000_0014, 32'h0, 4'hC, 32'h0BAD_F00D, 2, 0, 5,
                     1'b0, 32'h0BAD_F00D, 3));
    tbl.push_back(mk(1'b1, 32'h3000_0018, 32'h0F0F_0F0F, 4'h3, 32'hFFFF_FFFF, 1, 0, 0,
                     1'b0, 32'h0, 2));
`ifdef WB_HOST_MASTER_ERR_EN
    tbl.push_back(mk(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h5555_AAAA, 2, 2, 0,
                     1'b0, 32'h5555_AAAA, 3));
    tbl.push_back(mk(1'b0, 32'h3000_0024, 32'h0, 4'hF, 32'h5555_AAAA, 0, 3, 0,
                     1'b1, 32'h0, 4));
    tbl.push_back(mk(1'b1, 32'h3000_0028, 32'h1, 4'hF, 32'h0, 5, 2, 0,
                     1'b1, 32'h0, 3));
`endif
    // Randomized vectors checked against the model
    for (int i = 0; i < 24; i++) begin
      logic        rw;
      logic [31:0] rsd;
      logic        ee;
      logic [31:0] ed;
      int          el, ad, erd;
      rw  = 1'($urandom);
      rsd = $urandom;
      ad  = int'($urandom_range(0, TO + 2));
`ifdef WB_HOST_MASTER_ERR_EN
      erd = int'($urandom_range(0, TO + 2));
`else
      erd = 0;
`endif
      model(rw, rsd, ad, erd, ee, ed, el);
      v = mk(rw, $urandom, $urandom, 4'($urandom_range(1, 15)), rsd, ad, erd,
             int'($urandom_range(0, 3)), ee, ed, el);
      tbl.push_back(v);
    end

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Reset during BUS, then a late ack that must be ignored
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_cyc_before_rst", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cyc", 32'(cyc), 32'd0);
    chk("rst_mid_stb", 32'(stb), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    ack = 1'b1; sdat = 32'h7777_7777;
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_ack_cyc", 32'(cyc), 32'd0);
    chk("late_ack_ready", 32'(cmd_ready), 32'd1);
    // Normal operation resumes after the reset
    run_vec(mk(1'b0, 32'h3000_0044, 32'h0, 4'hF, 32'h2468_ACE0, 1, 0, 0,
               1'b0, 32'h2468_ACE0, 2), 999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
